// File: rtl/instr_sequencer.sv
// Instruction register, microstep counter and control-word decoder for the 8-bit bus CPU.
// Optional macro STEP_SKIP_EN: return to T0 right after an instruction's last non-empty step.
module instr_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_instr,
  input  logic        i_carry,
  input  logic        i_zero,
  output logic [15:0] o_ctrl,
  output logic [3:0]  o_operand,
  output logic [3:0]  o_opcode,
  output logic [2:0]  o_step,
  output logic        o_halted
);

  localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000, C_RO = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800, C_II = 16'h0400, C_AI = 16'h0200, C_AO = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080, C_SU = 16'h0040, C_BI = 16'h0020, C_OI = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008, C_CO = 16'h0004, C_J  = 16'h0002, C_FI = 16'h0001;
  localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  logic [7:0]  ir;
  logic [2:0]  step, step_nxt;
  logic        halted;
  logic [15:0] raw_ctrl;

  function automatic logic [15:0] decode(logic [2:0] s, logic [3:0] op, logic c, logic z);
    logic [15:0] d;
    d = '0;
    case (s)
      3'd0: d = C_CO | C_MI;
      3'd1: d = C_RO | C_II | C_CE;
      3'd2: case (op)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: d = C_IO | C_MI;
        OP_LDI: d = C_IO | C_AI;
        OP_JMP: d = C_IO | C_J;
        OP_JC:  d = c ? (C_IO | C_J) : '0;
        OP_JZ:  d = z ? (C_IO | C_J) : '0;
        OP_OUT: d = C_AO | C_OI;
        OP_HLT: d = C_HLT;
        default: d = '0;
      endcase
      3'd3: case (op)
        OP_LDA:         d = C_RO | C_AI;
        OP_ADD, OP_SUB: d = C_RO | C_BI;
        OP_STA:         d = C_AO | C_RI;
        default:        d = '0;
      endcase
      3'd4: case (op)
        OP_ADD:  d = C_EO | C_AI | C_FI;
        OP_SUB:  d = C_EO | C_SU | C_AI | C_FI;
        default: d = '0;
      endcase
      default: d = '0;
    endcase
    return d;
  endfunction

`ifdef STEP_SKIP_EN
  function automatic logic [2:0] last_used(logic [3:0] op, logic c, logic z);
    case (op)
      OP_ADD, OP_SUB:                 return 3'd4;
      OP_LDA, OP_STA:                 return 3'd3;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: return 3'd2;
      OP_JC:                          return c ? 3'd2 : 3'd1;
      OP_JZ:                          return z ? 3'd2 : 3'd1;
      default:                        return 3'd1;
    endcase
  endfunction

  // At T1 the IR still holds the previous word, so the skip decision looks at the ROM output.
  logic [2:0] last_step;
  always_comb begin
    last_step = (step == 3'd1) ? last_used(i_instr[7:4], i_carry, i_zero)
                               : last_used(ir[7:4], i_carry, i_zero);
    step_nxt  = (step == LAST_STEP || (step != 3'd0 && step == last_step)) ? 3'd0 : step + 3'd1;
  end
`else
  always_comb begin
    step_nxt = (step == LAST_STEP) ? 3'd0 : step + 3'd1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ir     <= 8'h00;
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (i_enable && !halted) begin
      if (step == 3'd1) ir <= i_instr;
      if (step == 3'd2 && ir[7:4] == OP_HLT) halted <= 1'b1;
      else                                   step   <= step_nxt;
    end
  end

  // Reset gates the outputs directly so no control pulse survives into the reset window.
  always_comb begin
    raw_ctrl = decode(step, ir[7:4], i_carry, i_zero);
    o_ctrl   = '0;
    if (!i_rst_n)      o_ctrl = '0;
    else if (halted)   o_ctrl = C_HLT;
    else if (i_enable) o_ctrl = raw_ctrl;
  end

  assign o_operand = ((o_ctrl & C_IO) != '0) ? ir[3:0] : 4'h0;
  assign o_opcode  = ir[7:4];
  assign o_step    = step;
  assign o_halted  = halted;

endmodule
